// File: rtl/trap_pkg.sv
// Shared constants and types for the machine-mode trap sequencer (exu_trap_seq).
package trap_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;

    localparam logic [31:0] CAUSE_ILG   = 32'd2;
    localparam logic [31:0] CAUSE_BRK   = 32'd3;
    localparam logic [31:0] CAUSE_ECALL = 32'd11;
    localparam logic [31:0] CAUSE_MSI   = 32'd3;
    localparam logic [31:0] CAUSE_MTI   = 32'd7;
    localparam logic [31:0] CAUSE_MEI   = 32'd11;
    localparam logic [31:0] CAUSE_IRQ   = 32'h8000_0000;

    localparam int IRQ_SW_BIT  = 3;
    localparam int IRQ_TMR_BIT = 7;
    localparam int IRQ_EXT_BIT = 11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAVE    = 2'd1,
        RESTORE = 2'd2,
        REDIR   = 2'd3
    } state_t;

endpackage

// File: rtl/exu_trap_seq_if.sv
// EX boundary beat and IFU flush/redirect handshake of the trap sequencer.
interface exu_trap_seq_if #(
    parameter int PC_W = 32
);
    logic            hs_ex4tc_vld;
    logic            hs_ex4tc_rdy;
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
    logic            ecall;
    logic            ebreak;
    logic            ilg;
    logic            mret;
    logic            flush;
    logic [PC_W-1:0] redir_pc;
    logic            hs_tc4if_rdy;

    modport master (
        output hs_ex4tc_vld, pc, instr, ecall, ebreak, ilg, mret, hs_tc4if_rdy,
        input  hs_ex4tc_rdy, flush, redir_pc
    );

    modport slave (
        input  hs_ex4tc_vld, pc, instr, ecall, ebreak, ilg, mret, hs_tc4if_rdy,
        output hs_ex4tc_rdy, flush, redir_pc
    );
endinterface

// File: rtl/trap_prio.sv
// Boundary priority encoder: enabled interrupts first (EXT > SW > TMR), then ilg > ecall > ebreak, then mret.
module trap_prio
    import trap_pkg::*;
(
    input  logic        i_ilg,
    input  logic        i_ecall,
    input  logic        i_ebreak,
    input  logic        i_mret,
    input  logic        i_irq_ext,
    input  logic        i_irq_sw,
    input  logic        i_irq_tmr,
    input  logic        i_mie_ext,
    input  logic        i_mie_sw,
    input  logic        i_mie_tmr,
    input  logic        i_mstatus_mie,
    output logic        o_take,
    output logic        o_is_irq,
    output logic        o_is_mret,
    output logic [31:0] o_cause
);
    logic w_ext;
    logic w_sw;
    logic w_tmr;
    logic w_irq;

    assign w_ext = i_irq_ext & i_mie_ext;
    assign w_sw  = i_irq_sw  & i_mie_sw;
    assign w_tmr = i_irq_tmr & i_mie_tmr;
    assign w_irq = i_mstatus_mie & (w_ext | w_sw | w_tmr);

    always_comb begin
        o_take    = 1'b0;
        o_is_irq  = 1'b0;
        o_is_mret = 1'b0;
        o_cause   = '0;
        if (w_irq) begin
            o_take   = 1'b1;
            o_is_irq = 1'b1;
            if (w_ext)     o_cause = CAUSE_IRQ | CAUSE_MEI;
            else if (w_sw) o_cause = CAUSE_IRQ | CAUSE_MSI;
            else           o_cause = CAUSE_IRQ | CAUSE_MTI;
        end else if (i_ilg) begin
            o_take  = 1'b1;
            o_cause = CAUSE_ILG;
        end else if (i_ecall) begin
            o_take  = 1'b1;
            o_cause = CAUSE_ECALL;
        end else if (i_ebreak) begin
            o_take  = 1'b1;
            o_cause = CAUSE_BRK;
        end else if (i_mret) begin
            o_is_mret = 1'b1;
        end
    end
endmodule

// File: rtl/exu_trap_seq.sv
// Machine-mode trap sequencer: takes traps/mret at the EX boundary, updates trap CSRs, redirects the IFU.
// Optional mtval register is built when TRAP_MTVAL_EN is defined.
module exu_trap_seq
    import trap_pkg::*;
#(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
    parameter int          PC_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    exu_trap_seq_if.slave        bus,
    input  logic                 i_irq_ext,
    input  logic                 i_irq_sw,
    input  logic                 i_irq_tmr,
    input  logic                 i_csr_we,
    input  logic [11:0]          i_csr_addr,
    input  logic [31:0]          i_csr_wdata,
    output logic [31:0]          o_csr_rdata,
    output logic                 o_busy
);
    // state   | meaning
    // IDLE    | accepting boundary beats and CSR writes
    // SAVE    | writing mepc/mcause/mstatus (and mtval) for a trap
    // RESTORE | restoring mstatus.MIE for mret
    // REDIR   | flush + redirect held until the IFU accepts

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [31:0]     r_cause;
    logic            r_is_irq;
    logic            r_mstatus_mie;
    logic            r_mstatus_mpie;
    logic            r_mie_ext;
    logic            r_mie_sw;
    logic            r_mie_tmr;
    logic [PC_W-1:0] r_mepc;
    logic [31:0]     r_mcause;
    logic [31:0]     r_mscratch;
    logic [PC_W-1:0] r_mtvec;
    logic [PC_W-1:0] r_redir_pc;
    logic [31:0]     w_mtval;

    logic            w_accept;
    logic            w_csr_wr;
    logic            w_take;
    logic            w_is_irq;
    logic            w_is_mret;
    logic [31:0]     w_cause;
    logic [PC_W-1:0] w_trap_tgt;

    assign w_accept = bus.hs_ex4tc_vld & (r_state == IDLE);
    assign w_csr_wr = i_csr_we & (r_state == IDLE);

    trap_prio u_prio (
        .i_ilg         (bus.ilg),
        .i_ecall       (bus.ecall),
        .i_ebreak      (bus.ebreak),
        .i_mret        (bus.mret),
        .i_irq_ext     (i_irq_ext),
        .i_irq_sw      (i_irq_sw),
        .i_irq_tmr     (i_irq_tmr),
        .i_mie_ext     (r_mie_ext),
        .i_mie_sw      (r_mie_sw),
        .i_mie_tmr     (r_mie_tmr),
        .i_mstatus_mie (r_mstatus_mie),
        .o_take        (w_take),
        .o_is_irq      (w_is_irq),
        .o_is_mret     (w_is_mret),
        .o_cause       (w_cause)
    );

    // Vectored mode only offsets interrupts; exceptions always land on the base.
    assign w_trap_tgt = {r_mtvec[PC_W-1:2], 2'b00}
                      + ((r_mtvec[1:0] == 2'b01 && r_is_irq) ? PC_W'({r_cause[4:0], 2'b00}) : '0);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && w_take)         w_state_nxt = SAVE;
                else if (w_accept && w_is_mret) w_state_nxt = RESTORE;
            end
            SAVE:    w_state_nxt = REDIR;
            RESTORE: w_state_nxt = REDIR;
            REDIR:   if (bus.hs_tc4if_rdy) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc           <= '0;
            r_cause        <= '0;
            r_is_irq       <= 1'b0;
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie_ext      <= 1'b0;
            r_mie_sw       <= 1'b0;
            r_mie_tmr      <= 1'b0;
            r_mepc         <= '0;
            r_mcause       <= '0;
            r_mscratch     <= '0;
            r_mtvec        <= PC_W'(MTVEC_RST);
            r_redir_pc     <= '0;
        end else begin
            if (w_accept && w_take) begin
                r_pc     <= bus.pc;
                r_cause  <= w_cause;
                r_is_irq <= w_is_irq;
            end
            case (r_state)
                IDLE: begin
                    if (w_csr_wr) begin
                        case (i_csr_addr)
                            CSR_MSTATUS: begin
                                r_mstatus_mie  <= i_csr_wdata[3];
                                r_mstatus_mpie <= i_csr_wdata[7];
                            end
                            CSR_MIE: begin
                                r_mie_sw  <= i_csr_wdata[IRQ_SW_BIT];
                                r_mie_tmr <= i_csr_wdata[IRQ_TMR_BIT];
                                r_mie_ext <= i_csr_wdata[IRQ_EXT_BIT];
                            end
                            CSR_MTVEC:    r_mtvec <= PC_W'({i_csr_wdata[31:2],
                                                            (i_csr_wdata[1] ? 2'b00 : i_csr_wdata[1:0])});
                            CSR_MSCRATCH: r_mscratch <= i_csr_wdata;
                            CSR_MEPC:     r_mepc <= PC_W'({i_csr_wdata[31:2], 2'b00});
                            CSR_MCAUSE:   r_mcause <= i_csr_wdata;
                            default: ;
                        endcase
                    end
                end
                SAVE: begin
                    r_mepc         <= {r_pc[PC_W-1:2], 2'b00};
                    r_mcause       <= r_cause;
                    r_mstatus_mpie <= r_mstatus_mie;
                    r_mstatus_mie  <= 1'b0;
                    r_redir_pc     <= w_trap_tgt;
                end
                RESTORE: begin
                    r_mstatus_mie  <= r_mstatus_mpie;
                    r_mstatus_mpie <= 1'b1;
                    r_redir_pc     <= r_mepc;
                end
                default: ;
            endcase
        end
    end

`ifdef TRAP_MTVAL_EN
    logic [31:0] r_instr;
    logic [31:0] r_mtval;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_instr <= '0;
            r_mtval <= '0;
        end else begin
            if (w_accept && w_take) r_instr <= bus.instr;
            if (r_state == SAVE) begin
                if (!r_is_irq && r_cause == CAUSE_ILG)      r_mtval <= r_instr;
                else if (!r_is_irq && r_cause == CAUSE_BRK) r_mtval <= 32'(r_pc);
                else                                        r_mtval <= '0;
            end else if (w_csr_wr && i_csr_addr == CSR_MTVAL) begin
                r_mtval <= i_csr_wdata;
            end
        end
    end

    assign w_mtval = r_mtval;
`else
    logic w_unused_instr;
    assign w_unused_instr = ^bus.instr;
    assign w_mtval        = '0;
`endif

    always_comb begin
        o_csr_rdata = '0;
        case (i_csr_addr)
            CSR_MSTATUS:  o_csr_rdata = {19'd0, 2'b11, 3'd0, r_mstatus_mpie, 3'd0, r_mstatus_mie, 3'd0};
            CSR_MIE:      o_csr_rdata = {20'd0, r_mie_ext, 3'd0, r_mie_tmr, 3'd0, r_mie_sw, 3'd0};
            CSR_MTVEC:    o_csr_rdata = 32'(r_mtvec);
            CSR_MSCRATCH: o_csr_rdata = r_mscratch;
            CSR_MEPC:     o_csr_rdata = 32'(r_mepc);
            CSR_MCAUSE:   o_csr_rdata = r_mcause;
            CSR_MTVAL:    o_csr_rdata = w_mtval;
            CSR_MIP:      o_csr_rdata = {20'd0, i_irq_ext, 3'd0, i_irq_tmr, 3'd0, i_irq_sw, 3'd0};
            default:      o_csr_rdata = '0;
        endcase
    end

    assign bus.hs_ex4tc_rdy = (r_state == IDLE);
    assign bus.flush        = (r_state == REDIR);
    assign bus.redir_pc     = r_redir_pc;
    assign o_busy           = (r_state != IDLE);

endmodule

// File: tb/tb_exu_trap_seq.sv
// Scoreboard bench for exu_trap_seq: redirect targets queued at stimulus, checked when o_flush rises.
module tb_exu_trap_seq;
    import trap_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        irq_ext, irq_sw, irq_tmr;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] sb[$];
    logic        prev_flush = 1'b0;

    exu_trap_seq_if #(.PC_W(32)) bus ();

    exu_trap_seq #(.MTVEC_RST(32'h0), .PC_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .i_irq_ext   (irq_ext),
        .i_irq_sw    (irq_sw),
        .i_irq_tmr   (irq_tmr),
        .i_csr_we    (csr_we),
        .i_csr_addr  (csr_addr),
        .i_csr_wdata (csr_wdata),
        .o_csr_rdata (csr_rdata),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] tgt(input logic [31:0] mtvec, input logic [31:0] cause, input logic irq);
        logic [31:0] t;
        t = {mtvec[31:2], 2'b00};
        if (irq && mtvec[1:0] == 2'b01) t = t + 32'(cause[4:0]) * 32'd4;
        return t;
    endfunction

    // Redirect monitor: one scoreboard entry per rising o_flush.
    always @(negedge clk) begin
        if (bus.flush && !prev_flush) begin
            if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else                chk("redir_pc", bus.redir_pc, sb.pop_front());
        end
        prev_flush = bus.flush;
    end

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        csr_we = 1'b1; csr_addr = a; csr_wdata = d;
        @(negedge clk);
        csr_we = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_addr = a;
        #1;
        chk(tag, csr_rdata, exp);
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] instr,
                        input logic ilg, input logic ecall, input logic ebreak, input logic mret);
        @(negedge clk);
        chk("rdy_at_beat", 32'(bus.hs_ex4tc_rdy), 32'd1);
        bus.hs_ex4tc_vld = 1'b1; bus.pc = pc; bus.instr = instr;
        bus.ilg = ilg; bus.ecall = ecall; bus.ebreak = ebreak; bus.mret = mret;
        @(negedge clk);
        bus.hs_ex4tc_vld = 1'b0; bus.ilg = 1'b0; bus.ecall = 1'b0; bus.ebreak = 1'b0; bus.mret = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        irq_ext = 0; irq_sw = 0; irq_tmr = 0;
        csr_we = 0; csr_addr = '0; csr_wdata = '0;
        bus.hs_ex4tc_vld = 0; bus.pc = '0; bus.instr = '0;
        bus.ilg = 0; bus.ecall = 0; bus.ebreak = 0; bus.mret = 0;
        bus.hs_tc4if_rdy = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_flush", 32'(bus.flush), 32'd0);
        chk("rst_redir", bus.redir_pc, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdy", 32'(bus.hs_ex4tc_rdy), 32'd1);
        rd_chk("rst_mstatus", CSR_MSTATUS, 32'h1800);
        rd_chk("rst_mtvec", CSR_MTVEC, 32'h0);
        rd_chk("rst_mepc", CSR_MEPC, 32'h0);
        rd_chk("rst_mtval", CSR_MTVAL, 32'h0);

        // Illegal + ecall together: illegal wins; check latency
        csr_wr(CSR_MTVEC, 32'h8000_0100);
        sb.push_back(tgt(32'h8000_0100, 32'd2, 1'b0));
        send(32'h1004, 32'h0, 1, 1, 0, 0);
        chk("lat_save_busy", 32'(busy), 32'd1);
        chk("lat_save_flush", 32'(bus.flush), 32'd0);
        @(negedge clk);
        chk("lat_redir_flush", 32'(bus.flush), 32'd1);
        @(negedge clk);
        chk("lat_drop_flush", 32'(bus.flush), 32'd0);
        chk("lat_idle", 32'(busy), 32'd0);
        rd_chk("t1_mcause", CSR_MCAUSE, 32'd2);
        rd_chk("t1_mepc", CSR_MEPC, 32'h1004);

        // ecall then mret
        csr_wr(CSR_MSTATUS, 32'h8);
        sb.push_back(tgt(32'h8000_0100, 32'd11, 1'b0));
        send(32'h2000, 32'h0, 0, 1, 0, 0);
        wait_idle();
        rd_chk("t2_mcause", CSR_MCAUSE, 32'd11);
        rd_chk("t2_mstatus_trap", CSR_MSTATUS, 32'h1880);
        rd_chk("t2_mepc", CSR_MEPC, 32'h2000);
        sb.push_back(32'h2000);
        send(32'h2100, 32'h0, 0, 0, 0, 1);
        wait_idle();
        rd_chk("t2_mstatus_mret", CSR_MSTATUS, 32'h1888);

        // External beats timer, vectored mode
        csr_wr(CSR_MIE, 32'h888);
        rd_chk("t3_mie", CSR_MIE, 32'h888);
        csr_wr(CSR_MTVEC, 32'h101);
        irq_tmr = 1; irq_ext = 1;
        rd_chk("t3_mip", CSR_MIP, 32'h880);
        sb.push_back(tgt(32'h101, 32'd11, 1'b1));
        send(32'h3000, 32'h0, 0, 0, 0, 0);
        wait_idle();
        rd_chk("t3_mcause", CSR_MCAUSE, 32'h8000_000B);
        rd_chk("t3_mepc", CSR_MEPC, 32'h3000);
        rd_chk("t3_mstatus", CSR_MSTATUS, 32'h1880);

        // Software beats timer and a concurrent ecall
        csr_wr(CSR_MSTATUS, 32'h8);
        irq_ext = 0; irq_sw = 1; irq_tmr = 1;
        sb.push_back(tgt(32'h101, 32'd3, 1'b1));
        send(32'h3100, 32'h0, 0, 1, 0, 0);
        wait_idle();
        rd_chk("t3b_mcause", CSR_MCAUSE, 32'h8000_0003);
        rd_chk("t3b_mtval", CSR_MTVAL, 32'h0);
        irq_sw = 0; irq_tmr = 0;

        // MIE=0: interrupt ignored, plain instruction retires
        irq_ext = 1;
        send(32'h4000, 32'h0, 0, 0, 0, 0);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_rdy", 32'(bus.hs_ex4tc_rdy), 32'd1);
        chk("t4_flush", 32'(bus.flush), 32'd0);
        rd_chk("t4_mcause", CSR_MCAUSE, 32'h8000_0003);
        irq_ext = 0;

        // CSR field boundaries
        csr_wr(CSR_MTVEC, 32'h202);
        rd_chk("mtvec_mode2", CSR_MTVEC, 32'h200);
        csr_wr(CSR_MTVEC, 32'h203);
        rd_chk("mtvec_mode3", CSR_MTVEC, 32'h200);
        csr_wr(CSR_MEPC, 32'h5003);
        rd_chk("mepc_align", CSR_MEPC, 32'h5000);
        csr_wr(12'h7C0, 32'hFFFF_FFFF);
        rd_chk("unmapped", 12'h7C0, 32'h0);
        csr_wr(CSR_MIP, 32'hFFF);
        rd_chk("mip_ro", CSR_MIP, 32'h0);
        csr_wr(CSR_MIE, 32'hFFFF_FFFF);
        rd_chk("mie_mask", CSR_MIE, 32'h888);
        csr_wr(CSR_MIE, 32'h0);

        // Stalled redirect, ignored write, reset mid-REDIR
        csr_wr(CSR_MTVEC, 32'h8000_0100);
        csr_wr(CSR_MSCRATCH, 32'h1234);
        rd_chk("mscratch_wr", CSR_MSCRATCH, 32'h1234);
        bus.hs_tc4if_rdy = 1'b0;
        sb.push_back(tgt(32'h8000_0100, 32'd3, 1'b0));
        send(32'h6002, 32'h0, 0, 0, 1, 0);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("stall_flush", 32'(bus.flush), 32'd1);
            chk("stall_redir", bus.redir_pc, 32'h8000_0100);
            @(negedge clk);
        end
        csr_wr(CSR_MSCRATCH, 32'hDEAD);
        chk("stall_flush2", 32'(bus.flush), 32'd1);
        chk("stall_redir2", bus.redir_pc, 32'h8000_0100);
        rd_chk("busy_wr_ignored", CSR_MSCRATCH, 32'h1234);
        rd_chk("t5_mcause", CSR_MCAUSE, 32'd3);
        rd_chk("t5_mepc", CSR_MEPC, 32'h6000);
`ifdef TRAP_MTVAL_EN
        rd_chk("t5_mtval", CSR_MTVAL, 32'h6002);
`else
        rd_chk("t5_mtval", CSR_MTVAL, 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.hs_tc4if_rdy = 1'b1;
        chk("rst_mid_flush", 32'(bus.flush), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_rdy", 32'(bus.hs_ex4tc_rdy), 32'd1);
        chk("rst_mid_redir", bus.redir_pc, 32'h0);
        rd_chk("rst_mid_mscratch", CSR_MSCRATCH, 32'h0);
        rd_chk("rst_mid_mcause", CSR_MCAUSE, 32'h0);

        // mtval on illegal instruction
        sb.push_back(tgt(32'h0, 32'd2, 1'b0));
        send(32'h7000, 32'hFFFF_FFFF, 1, 0, 0, 0);
        wait_idle();
        rd_chk("t6_mcause", CSR_MCAUSE, 32'd2);
        csr_addr = CSR_MTVAL; #1;
`ifdef TRAP_MTVAL_EN
        chk("t6_mtval", csr_rdata, 32'hFFFF_FFFF);
        csr_wr(CSR_MTVAL, 32'h55);
        rd_chk("t6_mtval_wr", CSR_MTVAL, 32'h55);
`else
        chk("t6_mtval", csr_rdata, 32'h0);
        csr_wr(CSR_MTVAL, 32'h55);
        rd_chk("t6_mtval_wr", CSR_MTVAL, 32'h0);
`endif

        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/exu_trap_seq.md
Name: exu_trap_seq

Overview:
- Machine-mode trap sequencer in the EXU.
- Prioritises synchronous exceptions (illegal, ecall, ebreak) and interrupts (external, software, timer) at the instruction boundary.
- Sequences the trap CSR updates (mepc, mcause, mstatus, optional mtval) and `mret` restore.
- Drives a flush/redirect handshake to the IFU.
- Owns the trap-related machine CSRs and exposes a simple read/write port to the CSR unit.

Parameters:
- MTVEC_RST, 32'h0000_0000, reset value of mtvec; bits [1:0] give the reset mode.
- PC_W, 32, width of PC and of trap CSRs.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous reset, active low
- hs_ex4tc_vld  in  1  EX presents a retiring instruction boundary
- hs_ex4tc_rdy  out  1  sequencer accepts the boundary
- i_pc  in  PC_W  PC of the presented instruction
- i_instr  in  32  encoding of the presented instruction
- i_ecall, i_ebreak, i_ilg, i_mret  in  1 each  decode flags of the presented instruction
- i_irq_ext, i_irq_sw, i_irq_tmr  in  1 each  level interrupt lines
- i_csr_we  in  1  CSR write strobe
- i_csr_addr  in  12  CSR address
- i_csr_wdata  in  32  CSR write data
- o_csr_rdata  out  32  combinational read data for i_csr_addr
- o_flush  out  1  flush request; doubles as redirect valid
- o_redir_pc  out  PC_W  redirect target
- hs_tc4if_rdy  in  1  IFU accepts the redirect
- o_busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; o_flush=0; o_redir_pc=0; mstatus.MIE=0, MPIE=0; mie=0; mepc=0; mcause=0; mscratch=0; mtval=0; mtvec=MTVEC_RST. Reset mid-sequence aborts it; no partial redirect is held.
- hs_ex4tc_rdy=1 only in IDLE. A beat is accepted when vld&rdy.
- irq_take = MIE & |(mip & mie), where mip = {ext@11, tmr@7, sw@3}.
- Priority on an accepted beat:
  - irq_take: EXT(11) > SW(3) > TMR(7); mcause[31]=1. The instruction is not executed.
  - else i_ilg: cause 2.
  - else i_ecall: cause 11.
  - else i_ebreak: cause 3.
  - else i_mret: restore path.
  - else no action; the instruction retires and the sequencer stays IDLE.
- States:
  - IDLE -> SAVE on accepted trap/interrupt: latch pc, cause and instr.
  - IDLE -> RESTORE on accepted mret.
  - SAVE, one cycle: mepc<=pc & ~3; mcause<=cause; MPIE<=MIE; MIE<=0; mtval per option. -> REDIR.
  - RESTORE, one cycle: MIE<=MPIE; MPIE<=1. -> REDIR.
  - REDIR: o_flush=1 and o_redir_pc stable until hs_tc4if_rdy. On the handshake -> IDLE and o_flush drops next cycle.
- Redirect target:
  - Trap: mtvec.base (mtvec[31:2]<<2). If mtvec[1:0]==1 and the cause is an interrupt, the target is base + 4*cause[4:0].
  - mret: mepc.
- Latency: accept at T; SAVE/RESTORE at T+1; o_flush=1 from T+2. Minimum 3 cycles back to IDLE.
- CSR port:
  - Addresses: mstatus 0x300 (MIE bit3, MPIE bit7, MPP[12:11] reads 2'b11, other bits 0), mie 0x304 (bits 3/7/11 writable), mtvec 0x305 (mode values 2/3 written as 0), mscratch 0x340, mepc 0x341 (bits [1:0] forced 0), mcause 0x342, mtval 0x343, mip 0x344 (read-only).
  - Unmapped reads return 0; writes to unmapped or read-only addresses are ignored.
  - Writes are applied only in IDLE and ignored otherwise. A write in the same cycle as an accepted trap takes effect; the trap update in SAVE then overwrites any overlapping field.
- Interrupt lines are levels, not latched. An interrupt de-asserted before the IDLE accept is not taken; one asserted while busy is evaluated at the next IDLE accept.

Optional Feature:
- TRAP_MTVAL_EN defined:
  - mtval register implemented.
  - SAVE writes i_instr for cause 2, pc for cause 3, and 0 otherwise.
  - Software-writable.
- TRAP_MTVAL_EN undefined: mtval reads 0 and writes are ignored.

Decomposition:
- Shared package `trap_pkg`:
  - CSR address constants.
  - Cause codes: ILG=2, BRK=3, ECALL=11, MSI=3, MTI=7, MEI=11.
  - mip/mie bit positions.
  - State enum {IDLE, SAVE, RESTORE, REDIR}.
- One sub-module, `trap_prio`: combinational priority encoder taking flags, irq lines, mie and MIE; outputs take, is_irq, is_mret and cause[31:0].

Test Plan:
- Illegal+ecall together, mtvec=0x8000_0100, pc=0x1004 -> mcause=2, mepc=0x1004; o_flush at T+2 with redir 0x8000_0100.
- ecall at pc=0x2000, then mret -> mcause=11, MIE 1->0, MPIE=1; mret redirects to 0x2000 with MIE=1 again.
- MIE=1, mie=0x888, irq_tmr and irq_ext high, mtvec=0x100|1 -> mcause=0x8000_000B; redir 0x12C.
- MIE=0 with irq_ext high and a plain instruction -> no trap; hs_ex4tc_rdy stays 1.
- REDIR with hs_tc4if_rdy held low 4 cycles -> o_flush and o_redir_pc stable; CSR write to mscratch ignored; rst_n pulled low mid-REDIR -> IDLE, o_flush=0 next cycle.
- TRAP_MTVAL_EN: ilg with instr=0xFFFF_FFFF -> mtval=0xFFFF_FFFF; without the macro, mtval reads 0.
